// File: rtl/nt_access_sequencer.sv
// Neighbor-table access sequencer: arbitrates packet-driven table updates (lookup, QTU,
// write-back) against findMyBest scans, and owns the neighbor count.
module nt_access_sequencer #(
    parameter int MAX_NEIGHBORS = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int WORD_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  upd_req,
    input  logic [WORD_WIDTH-1:0] upd_srcID,
    output logic                  upd_ack,
    output logic                  upd_drop,
    input  logic                  fmb_req,
    output logic                  fmb_done,
    output logic                  nt_rd_en,
    output logic                  nt_wr_en,
    output logic [ADDR_WIDTH-1:0] nt_addr,
    input  logic [WORD_WIDTH-1:0] nt_rd_id,
    input  logic [WORD_WIDTH-1:0] nt_rd_hops,
    input  logic [WORD_WIDTH-1:0] nt_rd_q,
    output logic                  qtu_start,
    input  logic                  qtu_done,
    output logic [WORD_WIDTH-1:0] neighborCount,
    output logic [WORD_WIDTH-1:0] best_id,
    output logic [WORD_WIDTH-1:0] best_hops,
    output logic [WORD_WIDTH-1:0] best_q,
    output logic                  best_valid,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE, U_SCAN, U_QTU, U_WRITE, U_ACK, F_SCAN, F_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   scan_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] slot;
    logic                  rd_pend;
    logic                  is_new;
    logic                  drop;
    logic                  qtu_issued;
    logic [WORD_WIDTH-1:0] run_id, run_hops, run_q;
    logic                  run_valid;
    logic                  scan_end, hit, full, better;

    assign scan_end = (WORD_WIDTH'(scan_addr) == neighborCount);
    assign full     = (neighborCount == WORD_WIDTH'(MAX_NEIGHBORS));
    // A hit suppresses the read issued in the same cycle, so the scan stops at the match.
    assign hit      = (state == U_SCAN) && rd_pend && (nt_rd_id == upd_srcID);
    assign better   = !run_valid || (nt_rd_hops < run_hops) ||
                      ((nt_rd_hops == run_hops) && (nt_rd_q > run_q));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        nt_rd_en  = 1'b0;
        nt_wr_en  = 1'b0;
        nt_addr   = '0;
        qtu_start = 1'b0;
        upd_ack   = 1'b0;
        upd_drop  = 1'b0;
        fmb_done  = 1'b0;
        case (state)
            IDLE: begin
                if (upd_req)      state_nxt = U_SCAN;
                else if (fmb_req) state_nxt = F_SCAN;
            end
            U_SCAN: begin
                nt_addr = scan_addr[ADDR_WIDTH-1:0];
                if (hit)            state_nxt = U_QTU;
                else if (!scan_end) nt_rd_en  = 1'b1;
                else if (full)      state_nxt = U_ACK;
                else                state_nxt = U_QTU;
            end
            U_QTU: begin
                nt_addr   = slot;
                qtu_start = !qtu_issued;
                if (qtu_done) state_nxt = U_WRITE;
            end
            U_WRITE: begin
                nt_addr   = slot;
                nt_wr_en  = 1'b1;
                state_nxt = U_ACK;
            end
            U_ACK: begin
                upd_ack   = 1'b1;
                upd_drop  = drop;
                state_nxt = IDLE;
            end
            F_SCAN: begin
                nt_addr = scan_addr[ADDR_WIDTH-1:0];
                if (!scan_end) nt_rd_en  = 1'b1;
                else           state_nxt = F_DONE;
            end
            F_DONE: begin
                fmb_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scan_addr     <= '0;
            rd_addr       <= '0;
            slot          <= '0;
            rd_pend       <= 1'b0;
            is_new        <= 1'b0;
            drop          <= 1'b0;
            qtu_issued    <= 1'b0;
            run_id        <= '0;
            run_hops      <= '0;
            run_q         <= '0;
            run_valid     <= 1'b0;
            neighborCount <= '0;
            best_id       <= '0;
            best_hops     <= '0;
            best_q        <= '0;
            best_valid    <= 1'b0;
        end else begin
            rd_pend    <= nt_rd_en;
            qtu_issued <= (state == U_QTU);
            if (nt_rd_en) rd_addr <= scan_addr[ADDR_WIDTH-1:0];
            if (state == IDLE)  scan_addr <= '0;
            else if (nt_rd_en)  scan_addr <= scan_addr + (ADDR_WIDTH+1)'(1);
            case (state)
                IDLE: begin
                    run_valid <= 1'b0;
                    run_id    <= '0;
                    run_hops  <= '0;
                    run_q     <= '0;
                end
                U_SCAN: begin
                    if (hit) begin
                        slot   <= rd_addr;
                        is_new <= 1'b0;
                        drop   <= 1'b0;
                    end else if (scan_end) begin
                        slot   <= scan_addr[ADDR_WIDTH-1:0];
                        is_new <= 1'b1;
                        drop   <= full;
                    end
                end
                U_WRITE: begin
                    if (is_new) neighborCount <= neighborCount + WORD_WIDTH'(1);
                end
                F_SCAN: begin
                    // Strict compares keep the lowest address among exact ties.
                    if (rd_pend && better) begin
                        run_id    <= nt_rd_id;
                        run_hops  <= nt_rd_hops;
                        run_q     <= nt_rd_q;
                        run_valid <= 1'b1;
                    end
                end
                F_DONE: begin
                    best_id    <= run_id;
                    best_hops  <= run_hops;
                    best_q     <= run_q;
                    best_valid <= run_valid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nt_access_sequencer.sv
// Directed bench for nt_access_sequencer: table-driven update vectors plus hand-written
// sequences for reset, arbitration, findMyBest and the full-table drop.
module tb_nt_access_sequencer;
    localparam int AW   = 4;
    localparam int WW   = 16;
    localparam int MAXN = 16;

    logic          clk = 1'b0, nrst = 1'b0;
    logic          upd_req = 1'b0, fmb_req = 1'b0, qtu_done = 1'b0;
    logic [WW-1:0] upd_srcID = '0;
    logic [WW-1:0] rd_id = '0, rd_hops = '0, rd_q = '0;
    logic          upd_ack, upd_drop, fmb_done, nt_rd_en, nt_wr_en, qtu_start;
    logic          best_valid, busy;
    logic [AW-1:0] nt_addr;
    logic [WW-1:0] neighborCount, best_id, best_hops, best_q;

    always #5 clk = ~clk;

    nt_access_sequencer #(.MAX_NEIGHBORS(MAXN), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk(clk), .nrst(nrst),
        .upd_req(upd_req), .upd_srcID(upd_srcID), .upd_ack(upd_ack), .upd_drop(upd_drop),
        .fmb_req(fmb_req), .fmb_done(fmb_done),
        .nt_rd_en(nt_rd_en), .nt_wr_en(nt_wr_en), .nt_addr(nt_addr),
        .nt_rd_id(rd_id), .nt_rd_hops(rd_hops), .nt_rd_q(rd_q),
        .qtu_start(qtu_start), .qtu_done(qtu_done),
        .neighborCount(neighborCount), .best_id(best_id), .best_hops(best_hops),
        .best_q(best_q), .best_valid(best_valid), .busy(busy)
    );

    function automatic logic [WW-1:0] hops_of(input logic [WW-1:0] id);
        case (id)
            16'd3:                hops_of = 16'd2;
            16'd7, 16'd9, 16'd4:  hops_of = 16'd1;
            default:              hops_of = 16'd3;
        endcase
    endfunction

    function automatic logic [WW-1:0] q_of(input logic [WW-1:0] id);
        case (id)
            16'd3:         q_of = 16'h10;
            16'd7:         q_of = 16'h08;
            16'd9, 16'd4:  q_of = 16'h20;
            default:       q_of = 16'hFF;
        endcase
    endfunction

    // Neighbor-table RAM: one-cycle read latency; writes store the pending srcID.
    logic [WW-1:0] mem_id [MAXN];
    logic [WW-1:0] mem_hops [MAXN];
    logic [WW-1:0] mem_q [MAXN];
    always @(posedge clk) begin
        if (nt_rd_en) begin
            rd_id   <= mem_id[nt_addr];
            rd_hops <= mem_hops[nt_addr];
            rd_q    <= mem_q[nt_addr];
        end
        if (nt_wr_en) begin
            mem_id[nt_addr]   <= upd_srcID;
            mem_hops[nt_addr] <= hops_of(upd_srcID);
            mem_q[nt_addr]    <= q_of(upd_srcID);
        end
    end

    // Mid-cycle monitor and QTU model (qtu_done pulses qtu_delay cycles after qtu_start).
    int cyc = 0, rd_cnt = 0, qtu_cnt = 0, wr_cnt = 0, ack_cnt = 0, fmb_cnt = 0;
    int both_err = 0, addr_err = 0, ack_cyc = 0, fmb_cyc = 0, rd_at_ack = 0;
    int qtu_timer = 0, qtu_delay = 1;
    logic [AW-1:0] qtu_addr = '0, wr_addr = '0;
    logic          ack_drop = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (nt_rd_en) rd_cnt++;
        if (nt_rd_en && nt_wr_en) both_err++;
        if (!busy && nt_addr != '0) addr_err++;
        if (nt_wr_en) begin wr_cnt++; wr_addr = nt_addr; end
        if (upd_ack) begin ack_cnt++; ack_drop = upd_drop; ack_cyc = cyc; rd_at_ack = rd_cnt; end
        if (fmb_done) begin fmb_cnt++; fmb_cyc = cyc; end
        qtu_done = 1'b0;
        if (qtu_timer != 0) begin
            qtu_timer--;
            if (qtu_timer == 0) qtu_done = 1'b1;
        end
        if (qtu_start) begin qtu_cnt++; qtu_addr = nt_addr; qtu_timer = qtu_delay; end
        if (!nrst) qtu_timer = 0;
    end

    int nchk = 0, nerr = 0;
    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int r_lat, r_reads, r_qtu, r_wr, r_qaddr, r_waddr, r_drop;

    task automatic do_upd(input logic [WW-1:0] id, input int dly);
        int rb, qb, wb, ab, t0;
        bit got;
        qtu_delay = dly;
        rb = rd_cnt; qb = qtu_cnt; wb = wr_cnt; ab = ack_cnt; t0 = cyc + 1;
        upd_srcID = id;
        upd_req   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (ack_cnt != ab) got = 1'b1;
        end
        upd_req = 1'b0;
        chk("upd_ack_seen", int'(got), 1);
        r_lat   = ack_cyc - t0;
        r_reads = rd_cnt - rb;
        r_qtu   = qtu_cnt - qb;
        r_wr    = wr_cnt - wb;
        r_qaddr = int'(qtu_addr);
        r_waddr = int'(wr_addr);
        r_drop  = int'(ack_drop);
    endtask

    task automatic do_fmb();
        int fb, t0;
        bit got;
        fb = fmb_cnt; t0 = cyc + 1;
        fmb_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            if (fmb_cnt != fb) got = 1'b1;
        end
        fmb_req = 1'b0;
        chk("fmb_done_seen", int'(got), 1);
        r_lat = fmb_cyc - t0;
    endtask

    typedef struct {
        logic [WW-1:0] id;
        int            dly;
        int            slot;
        int            reads;
        int            cnt;
        int            lat;
    } uvec_t;
    uvec_t vt [5];

    initial begin
        int rb, ab, fb, wb, qb, t0;
        bit got;
        // id, qtu delay, slot, reads, count after, ack latency
        vt[0] = '{16'd3, 1, 0, 0, 1, 5};
        vt[1] = '{16'd7, 2, 1, 1, 2, 7};
        vt[2] = '{16'd9, 1, 2, 2, 3, 7};
        vt[3] = '{16'd7, 1, 1, 2, 3, 7};
        vt[4] = '{16'd4, 4, 3, 3, 4, 11};

        #2;
        chk("rst_count", int'(neighborCount), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ctrl", int'({upd_ack, upd_drop, fmb_done, nt_rd_en, nt_wr_en, qtu_start,
                               nt_addr, best_valid}), 0);
        chk("rst_best", int'({best_id, best_hops}) | int'(best_q), 0);
        repeat (2) step();
        nrst = 1'b1;
        step();

        // New entry in an empty table, QTU answering 3 cycles after start
        do_upd(16'd5, 3);
        chk("empty_lat", r_lat, 7);
        chk("empty_reads", r_reads, 0);
        chk("empty_qtu", r_qtu, 1);
        chk("empty_qaddr", r_qaddr, 0);
        chk("empty_wr", r_wr, 1);
        chk("empty_waddr", r_waddr, 0);
        chk("empty_drop", r_drop, 0);
        chk("empty_count", int'(neighborCount), 1);

        // Reset while waiting on the QTU
        qtu_delay = 5;
        qb = qtu_cnt; wb = wr_cnt; ab = ack_cnt;
        upd_srcID = 16'd6;
        upd_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (qtu_cnt != qb) got = 1'b1;
        end
        chk("midrst_qtu_seen", int'(got), 1);
        chk("midrst_busy_before", int'(busy), 1);
        nrst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_addr", int'(nt_addr), 0);
        chk("midrst_count", int'(neighborCount), 0);
        chk("midrst_ctrl", int'({upd_ack, fmb_done, nt_rd_en, nt_wr_en, qtu_start}), 0);
        upd_req = 1'b0;
        repeat (2) step();
        nrst = 1'b1;
        repeat (10) step();
        chk("midrst_no_wr", wr_cnt - wb, 0);
        chk("midrst_no_ack", ack_cnt - ab, 0);
        chk("midrst_count_after", int'(neighborCount), 0);

        for (int i = 0; i < 5; i++) begin
            do_upd(vt[i].id, vt[i].dly);
            chk($sformatf("vec%0d_lat", i), r_lat, vt[i].lat);
            chk($sformatf("vec%0d_reads", i), r_reads, vt[i].reads);
            chk($sformatf("vec%0d_qtu", i), r_qtu, 1);
            chk($sformatf("vec%0d_qaddr", i), r_qaddr, vt[i].slot);
            chk($sformatf("vec%0d_wr", i), r_wr, 1);
            chk($sformatf("vec%0d_waddr", i), r_waddr, vt[i].slot);
            chk($sformatf("vec%0d_drop", i), r_drop, 0);
            chk($sformatf("vec%0d_count", i), int'(neighborCount), vt[i].cnt);
        end

        // findMyBest over (3,2,10) (7,1,08) (9,1,20) (4,1,20): 9 wins the tie by address
        do_fmb();
        chk("fmb4_lat", r_lat, 6);
        chk("fmb4_id", int'(best_id), 9);
        chk("fmb4_hops", int'(best_hops), 1);
        chk("fmb4_q", int'(best_q), 32);
        chk("fmb4_valid", int'(best_valid), 1);

        // Simultaneous requests: the update (hit on 9 at index 2) runs first
        qtu_delay = 1;
        rb = rd_cnt; ab = ack_cnt; fb = fmb_cnt; t0 = cyc + 1;
        upd_srcID = 16'd9;
        upd_req = 1'b1;
        fmb_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (ack_cnt != ab) got = 1'b1;
        end
        upd_req = 1'b0;
        chk("both_ack_seen", int'(got), 1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (fmb_cnt != fb) got = 1'b1;
        end
        fmb_req = 1'b0;
        chk("both_fmb_seen", int'(got), 1);
        chk("both_reads_at_ack", rd_at_ack - rb, 3);
        chk("both_reads_total", rd_cnt - rb, 7);
        chk("both_ack_lat", ack_cyc - t0, 8);
        chk("both_fmb_lat", fmb_cyc - t0, 15);
        chk("both_best_id", int'(best_id), 9);
        chk("both_count", int'(neighborCount), 4);

        // Fill to capacity, then an unknown ID must be dropped
        for (int i = 0; i < 12; i++) begin
            do_upd(WW'(10 + i), 1);
            chk($sformatf("fill%0d_slot", i), r_waddr, 4 + i);
        end
        chk("full_count", int'(neighborCount), 16);
        do_upd(16'd99, 2);
        chk("drop_lat", r_lat, 18);
        chk("drop_reads", r_reads, 16);
        chk("drop_qtu", r_qtu, 0);
        chk("drop_wr", r_wr, 0);
        chk("drop_flag", r_drop, 1);
        chk("drop_count", int'(neighborCount), 16);

        do_fmb();
        chk("fmb16_lat", r_lat, 18);
        chk("fmb16_id", int'(best_id), 9);
        chk("fmb16_q", int'(best_q), 32);

        chk("rd_wr_overlap", both_err, 0);
        chk("idle_addr_nonzero", addr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/nt_access_sequencer.md
Name: nt_access_sequencer

Overview:
- Controller that sequences the neighbor-table memory and the Q-table-update (QTU) datapath.
- Arbitrates two requesters:
  - packet-driven table update: lookup, QTU compute, write-back.
  - findMyBest scan: walk the table and select the best next hop.
- Sits between packetFilter, the neighbor-table RAM and the QTU datapath.
- Owns neighborCount.

Parameters:
- MAX_NEIGHBORS, 16, table capacity in entries.
- ADDR_WIDTH, 4, neighbor-table address width; equals log2(MAX_NEIGHBORS).
- WORD_WIDTH, 16, data word width.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset; asynchronous, active-low
- upd_req  in  1  level; packet pending; held until upd_ack
- upd_srcID  in  WORD_WIDTH  source ID of pending packet; stable while upd_req is high
- upd_ack  out  1  one-cycle pulse; update finished or dropped
- upd_drop  out  1  valid with upd_ack; 1 = new neighbor rejected because table full
- fmb_req  in  1  level; findMyBest request; held until fmb_done
- fmb_done  out  1  one-cycle pulse; best_* outputs updated
- nt_rd_en  out  1  memory read strobe
- nt_wr_en  out  1  memory write strobe, one cycle
- nt_addr  out  ADDR_WIDTH  memory address for read or write
- nt_rd_id  in  WORD_WIDTH  read data: node ID; valid the cycle after nt_rd_en
- nt_rd_hops  in  WORD_WIDTH  read data: hops
- nt_rd_q  in  WORD_WIDTH  read data: Q-value
- qtu_start  out  1  one-cycle pulse; start QTU computation for slot nt_addr
- qtu_done  in  1  QTU result ready; pulse
- neighborCount  out  WORD_WIDTH  number of valid entries
- best_id  out  WORD_WIDTH  findMyBest result: node ID
- best_hops  out  WORD_WIDTH  findMyBest result: hops
- best_q  out  WORD_WIDTH  findMyBest result: Q-value
- best_valid  out  1  1 if the last scan found at least one entry
- busy  out  1  state != IDLE

Behaviour:
- Reset (nrst low, async): state IDLE; every output 0, including neighborCount, best_* and best_valid. Reset mid-operation aborts the operation with no write and no ack.
- States:
  - IDLE, U_SCAN, U_QTU, U_WRITE, U_ACK, F_SCAN, F_DONE.
- Arbitration in IDLE:
  - upd_req takes priority over fmb_req.
  - If both are high, the update runs first; fmb_req is then serviced from IDLE on the next eligible cycle.
  - Requests are never accepted outside IDLE.
- Update scan (U_SCAN):
  - Reads addresses 0..neighborCount-1, one per cycle, nt_rd_en high.
  - Data returns with 1-cycle latency; compare nt_rd_id with upd_srcID.
  - First match sets slot = address and ends the scan; further reads stop, and the in-flight read is ignored.
  - No match: slot = neighborCount and new = 1.
  - neighborCount = 0: U_SCAN lasts one cycle with no reads; slot = 0, new = 1.
  - new = 1 and neighborCount = MAX_NEIGHBORS → go to U_ACK with upd_drop = 1. No QTU, no write.
- U_QTU:
  - qtu_start pulses in the first cycle, with nt_addr = slot.
  - nt_addr is held at slot until qtu_done.
  - No timeout; waits indefinitely.
- U_WRITE:
  - nt_wr_en high for one cycle at slot.
  - If new, neighborCount increments in the same cycle.
- U_ACK:
  - upd_ack pulses one cycle; upd_drop is valid in that cycle.
  - Return to IDLE.
- Findmybest scan (F_SCAN):
  - Reads all neighborCount entries.
  - Candidate is better if hops are lower; on equal hops, if Q is strictly higher (unsigned). Equal hops and equal Q keep the earlier (lower) address.
  - Running best registers are internal; best_* and best_valid are updated only in F_DONE.
  - neighborCount = 0: no reads; best_valid = 0 and best_* = 0.
- F_DONE: fmb_done pulses one cycle; return to IDLE.
- Latency with N = neighborCount:
  - Update hit at index k: ack no earlier than k+5 cycles after acceptance, plus QTU time.
  - Findmybest: fmb_done N+2 cycles after acceptance.
- nt_rd_en and nt_wr_en are never high in the same cycle.
- nt_addr is 0 when idle.

Test Plan:
- Empty table, upd_req with srcID=0x0005, QTU done 3 cycles after start → qtu_start at addr 0; nt_wr_en at addr 0; neighborCount=1; upd_ack with upd_drop=0.
- Table holds IDs {3,7,9}; upd_req srcID=7 → reads stop after addr 1; write at addr 1; neighborCount stays 3.
- Table full with 16 entries; upd_req with an unknown ID → 16 reads, no qtu_start, no write; upd_ack with upd_drop=1; count stays 16.
- Entries (id, hops, q) = (3,2,0x10), (7,1,0x08), (9,1,0x20), (4,1,0x20) → fmb_done after 6 cycles; best_id=9, best_hops=1, best_q=0x20, best_valid=1.
- upd_req and fmb_req asserted in the same cycle → update completes (upd_ack) before any F_SCAN read; fmb_done follows.
- nrst pulsed low during U_QTU → all outputs 0 immediately; no nt_wr_en and no upd_ack after release; neighborCount=0.
